seq_alu: RTL and testbench

- Parametrised, handshaked successor to the datapath's combinational ALU.
- Executes ADD/SUB/MOVE/SWAP/AND/OR/XOR in one registered cycle, plus a multi-cycle signed shift-add MUL.
- Produces a double-width result with correct signed-overflow and zero flags.
- Sits in the EX stage; a multi-cycle op stalls the pipeline through the ready/valid handshake.

---
 rtl/seq_alu.sv | 149 ++++++++++++++
 tb/tb_seq_alu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked EX-stage ALU with multi-cycle signed shift-add multiply
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               overflow,
    output logic               zero
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MOVE = 3'b010;
    localparam logic [2:0] OP_SWAP = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               state, state_d;
    logic [2*WIDTH-1:0]   result_d;
    logic                 overflow_d;
    logic [2*WIDTH-1:0]   mcand, mcand_d;
    logic [WIDTH-1:0]     mplier, mplier_d;
    logic [2*WIDTH-1:0]   acc, acc_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic                 sign, sign_d;

    logic                 accept;
    logic [WIDTH-1:0]     sum, diff, abs_a, abs_b;
    logic [2*WIDTH-1:0]   single_res, acc_next, product;
    logic                 single_ov;

    assign in_ready  = rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    function automatic logic [2*WIDTH-1:0] sext(input logic [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    // Single-cycle op results and the operand magnitudes a MUL starts from
    always_comb begin
        sum        = a + b;
        diff       = a - b;
        abs_a      = a[WIDTH-1] ? (~a + 1'b1) : a;
        abs_b      = b[WIDTH-1] ? (~b + 1'b1) : b;
        single_res = '0;
        single_ov  = 1'b0;
        case (op)
            OP_ADD: begin
                single_res = sext(sum);
                single_ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                single_res = sext(diff);
                single_ov  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MOVE: single_res = sext(b);
            OP_SWAP: single_res = {a, b};
            OP_AND:  single_res = sext(a & b);
            OP_OR:   single_res = sext(a | b);
            OP_XOR:  single_res = sext(a ^ b);
            default: single_res = '0;
        endcase
    end

    // Next state and datapath; the last MUL iteration writes the signed product straight to result
    always_comb begin
        state_d    = state;
        result_d   = result;
        overflow_d = overflow;
        mcand_d    = mcand;
        mplier_d   = mplier;
        acc_d      = acc;
        cnt_d      = cnt;
        sign_d     = sign;
        acc_next   = acc + (mplier[0] ? mcand : '0);
        product    = sign ? (~acc_next + 1'b1) : acc_next;
        case (state)
            MUL: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    result_d   = product;
                    overflow_d = (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}});
                    state_d    = DONE;
                end else begin
                    acc_d    = acc_next;
                    mcand_d  = mcand << 1;
                    mplier_d = mplier >> 1;
                    cnt_d    = cnt + 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, abs_a};
                        mplier_d = abs_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
                        state_d  = MUL;
                    end else begin
                        result_d   = single_res;
                        overflow_d = single_ov;
                        state_d    = DONE;
                    end
                end else if ((state == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State, result/flag and multiplier registers; zero is registered alongside result
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            result   <= '0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
        end else begin
            state    <= state_d;
            result   <= result_d;
            overflow <= overflow_d;
            zero     <= (result_d == '0);
            mcand    <= mcand_d;
            mplier   <= mplier_d;
            acc      <= acc_d;
            cnt      <= cnt_d;
            sign     <= sign_d;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu with scoreboard model and directed vectors
module tb_seq_alu;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [2:0]    op = 3'b000;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2*W-1:0] result;
    logic          overflow;
    logic          zero;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] exp_q[$];
    bit          hold_prev = 0;
    logic [34:0] hold_val;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference behaviour from plain integer arithmetic: returns {overflow, result}
    function automatic logic [32:0] model(input logic [15:0] ta, input logic [15:0] tb2, input logic [2:0] top);
        int sa, sb, s;
        logic [15:0] l;
        logic [31:0] r;
        logic ov;
        sa = int'($signed(ta));
        sb = int'($signed(tb2));
        ov = 1'b0;
        s  = 0;
        l  = 16'h0;
        case (top)
            3'd0: s = sa + sb;
            3'd1: s = sa - sb;
            3'd2: s = sb;
            3'd4: s = int'($signed(ta & tb2));
            3'd5: s = int'($signed(ta | tb2));
            3'd6: s = int'($signed(ta ^ tb2));
            3'd7: s = sa * sb;
            default: s = 0;
        endcase
        if (top == 3'd0 || top == 3'd1 || top == 3'd7) ov = (s > 32767) || (s < -32768);
        if (top == 3'd7) r = s;
        else if (top == 3'd3) r = {ta, tb2};
        else begin
            l = s[15:0];
            r = {{16{l[15]}}, l};
        end
        return {ov, r};
    endfunction

    // Scoreboard: record every accept, compare every completed handshake, watch held outputs
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst) begin
            exp_q.delete();
            hold_prev = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stale_out_valid", 64'(out_valid), 64'd0);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    chk("sb_result", 64'(result), 64'(e[31:0]));
                    chk("sb_overflow", 64'(overflow), 64'(e[32]));
                    chk("sb_zero", 64'(zero), 64'(e[31:0] == 32'd0));
                end
            end
            if (out_valid && !out_ready) begin
                if (hold_prev) chk("hold_stable", 64'({overflow, zero, out_valid, result}), 64'(hold_val));
                hold_val  = {overflow, zero, out_valid, result};
                hold_prev = 1;
            end else begin
                hold_prev = 0;
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, op));
        end
    end

    // One op with out_ready high; checks latency, in_ready low cycles and literal result
    task automatic run_op(input string name, input logic [15:0] ta, input logic [15:0] tb2, input logic [2:0] top,
                          input logic [31:0] eres, input logic eov, input int elat);
        int lat, busy, guard;
        out_ready = 1'b1;
        a = ta; b = tb2; op = top; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        chk({name, "_accept"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        busy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy++;
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(elat));
        chk({name, "_result"}, 64'(result), 64'(eres));
        chk({name, "_overflow"}, 64'(overflow), 64'(eov));
        chk({name, "_zero"}, 64'(zero), 64'(eres == 32'd0));
        if (top == 3'd7) chk({name, "_busy"}, 64'(busy), 64'(W));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bubbles, gaps, seen;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'({overflow, zero}), 64'd0);
        rst = 1'b1;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        run_op("add_ovf", 16'h7FFF, 16'h0001, 3'd0, 32'hFFFF8000, 1'b1, 1);
        run_op("sub_ovf", 16'h8000, 16'h0001, 3'd1, 32'h00007FFF, 1'b1, 1);
        run_op("swap",    16'h1234, 16'hABCD, 3'd3, 32'h1234ABCD, 1'b0, 1);
        run_op("xor_zero",16'h5A5A, 16'h5A5A, 3'd6, 32'h00000000, 1'b0, 1);
        run_op("move",    16'h0000, 16'h8001, 3'd2, 32'hFFFF8001, 1'b0, 1);
        run_op("and",     16'hF0F0, 16'h8FF0, 3'd4, 32'hFFFF80F0, 1'b0, 1);
        run_op("or",      16'h0012, 16'h0300, 3'd5, 32'h00000312, 1'b0, 1);
        run_op("mul_neg", 16'hFFFD, 16'h0007, 3'd7, 32'hFFFFFFEB, 1'b0, W + 1);
        run_op("mul_min", 16'h8000, 16'h8000, 3'd7, 32'h40000000, 1'b1, W + 1);
        run_op("mul_ovf", 16'h0100, 16'hFF00, 3'd7, 32'hFFFF0000, 1'b1, W + 1);

        // Backpressure: hold a finished ADD while a SUB waits
        run_op("bp_add", 16'h0100, 16'h0023, 3'd0, 32'h00000123, 1'b0, 1);
        out_ready = 1'b0;
        a = 16'h0005; b = 16'h0007; op = 3'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_result", 64'(result), 64'h00000123);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_result", 64'(result), 64'hFFFFFFFE);
        @(posedge clk); #1;
        chk("bp_drain", 64'(out_valid), 64'd0);

        // Throughput: eight back-to-back ADDs
        bubbles = 0;
        for (int i = 0; i < 8; i++) begin
            a = 16'(i * 4099 + 16'h7FF0); b = 16'(i * 301); op = 3'd0; in_valid = 1'b1;
            @(posedge clk); #1;
            if (!out_valid) bubbles++;
        end
        chk("tp_bubbles", 64'(bubbles), 64'd0);

        // MUL mid-stream
        a = 16'h0011; b = 16'hFFF0; op = 3'd7;
        @(posedge clk); #1;
        a = 16'h0002; b = 16'h0003; op = 3'd0;
        gaps = 0;
        while (!out_valid && gaps < 100) begin
            gaps++;
            @(posedge clk); #1;
        end
        chk("mid_mul_gap", 64'(gaps), 64'(W));
        chk("mid_mul_result", 64'(result), 64'hFFFFFEF0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_add_valid", 64'(out_valid), 64'd1);
        chk("mid_add_result", 64'(result), 64'h00000005);
        @(posedge clk); #1;

        // Reset in the middle of a MUL
        a = 16'h0003; b = 16'h0005; op = 3'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("postrst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("postrst_no_stale", 64'(seen), 64'd0);

        run_op("post_add", 16'hFFFF, 16'h0001, 3'd0, 32'h00000000, 1'b0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
